l1_icache: RTL and testbench
============================

# l1_icache

Direct-mapped, read-only L1 instruction cache that serves the fetch stage of the pipelined CPU. It answers the program counter's fetch address with an instruction in the same cycle on a hit. On a miss it raises `stall` so the PC and IF/ID hold, and refills one line from backing memory through a per-word request/ready handshake.

## Interface
- `ADDR_W`, 32: fetch and memory address width.
- `DATA_W`, 32: instruction and memory word width.
- `LINE_WORDS`, 4: words per line (power of 2, ≥2).
- `NUM_LINES`, 16: lines in the cache (power of 2).

- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: reset rst, synchronous, active-high.
- `cpu_req`  in  1: fetch request valid.
- `cpu_addr`  in  ADDR_W: byte fetch address (the PC value).
- `flush`  in  1: invalidate all lines.
- `instr`  out  DATA_W: fetched instruction.
- `stall`  out  1: fetch not satisfied this cycle; CPU must hold PC.
- `mem_req`  out  1: word read request to backing memory.
- `mem_addr`  out  ADDR_W: word-aligned read address.
- `mem_ready`  in  1: `mem_rdata` valid; beat accepted.
- `mem_rdata`  in  DATA_W: read data.
- `hit_cnt`  out  32: hits counted since reset.
- `miss_cnt`  out  32: misses counted since reset.

## Operation
- Address split, low to high:
  - `cpu_addr[1:0]`: ignored.
  - Word offset: log2(LINE_WORDS) bits.
  - Index: log2(NUM_LINES) bits.
  - Tag: the remaining bits (24 at defaults).
- Storage per line: valid bit, tag, LINE_WORDS data words.
- FSM states: IDLE, FILL.
- IDLE behaviour:
  - Hit (`cpu_req` and valid[index] and tag match): `instr` = stored word, `stall`=0, `hit_cnt`++.
  - Miss: `stall`=1, latch tag and index, clear beat counter, go to FILL, `miss_cnt`++ once per miss.
- FILL behaviour:
  - `mem_req`=1 and `stall`=1 throughout.
  - `mem_addr` = {latched tag, latched index, beat counter, 2'b00}.
  - On each `mem_ready`: write `mem_rdata` into word[beat] and increment the beat counter.
  - `mem_req` stays high across beats with no idle cycle between them.
  - On the last beat: write the tag, set valid, go to IDLE.
  - In IDLE the current `cpu_addr` is looked up again and now hits.
- Fill order is always word 0 upward; there is no critical-word-first.
- `instr` = 0 whenever there is no hit.
- `stall` and `instr` are combinational from state, the arrays and `cpu_addr`, so they are stable before the CPU samples them.
- `cpu_req`=0: `stall`=0, no counting, no fill.
- `flush` in IDLE clears all valid bits at the next edge.
  - A hit lookup in that same cycle still completes normally.
- `flush` during FILL sets a pending flag. When the fill completes, all valid bits are cleared, including the line just filled.
- Counters are 32-bit and wrap on overflow.
- Changes to `cpu_addr` during FILL do not affect the fill.

## Timing
- Hit: 0-cycle latency.
- Miss penalty = 1 cycle + LINE_WORDS beats. With `mem_ready` always high this is 5 cycles at defaults; the hit comes in cycle 6.
- `mem_ready` while `mem_req`=0 is ignored.
- Reset values:
  - FSM in IDLE, `mem_req`=0, `mem_addr`=0.
  - All valid bits 0, beat counter 0, flush-pending 0.
  - `hit_cnt`=0, `miss_cnt`=0.
- Immediately after reset, `cpu_req`=1 produces `stall`=1.
- Reset mid-fill: at the edge, go to IDLE and clear all valid bits. The partial line is never marked valid and `mem_req` drops that same edge.
- Data array contents are not reset.

## Structure
- Shared package holds:
  - Field width constants (OFFSET_W, INDEX_W, TAG_W) derived from the parameters.
  - The FSM state enum (IDLE, FILL).
  - An address field-extraction function.
- One sub-module, `icache_array`: valid/tag/data storage. It has a combinational read port and a synchronous single-word write port with clear-all-valid.
- The controller FSM, beat counter and performance counters sit in `l1_icache`.

## Test plan
- Reset, then `cpu_req`=1, `cpu_addr`=0x40, `mem_ready` always 1, `mem_rdata`=0xA0+beat.
  - Cycle 0: `stall`=1.
  - Cycles 1–4: `mem_addr` = 0x40, 0x44, 0x48, 0x4C.
  - Cycle 5: `stall`=0, `instr`=0xA0.
  - `miss_cnt`=1.
- After the previous fill, `cpu_addr`=0x48 → `instr`=0xA2, `stall`=0, `hit_cnt` increments. Then 0x140 (same index 4, tag 1) → miss, refill; 0x40 afterwards misses again.
- `mem_ready` asserted only every third cycle during a fill → `mem_req` held high continuously, `mem_addr` advances only on ready, `stall` lasts 1+12 cycles.
- `flush` pulsed during beat 2 of a fill → fill completes and returns to IDLE. The next fetch of the same address misses again; `miss_cnt`=2.
- `rst` asserted during beat 3 → `mem_req`=0 the next cycle, counters 0. Re-fetching 0x40 restarts the fill at 0x40.
- `cpu_req`=0 with the address changing → `stall`=0, `mem_req`=0, counters unchanged.

Source files
------------

// File: rtl/l1_icache_pkg.sv
// rtl/l1_icache_pkg.sv - shared geometry, FSM states and address split for l1_icache
package l1_icache_pkg;

  // Cache geometry; the l1_icache parameters are expected to match these
  localparam int CFG_ADDR_W     = 32;
  localparam int CFG_DATA_W     = 32;
  localparam int CFG_LINE_WORDS = 4;
  localparam int CFG_NUM_LINES  = 16;

  localparam int OFFSET_W = $clog2(CFG_LINE_WORDS);
  localparam int INDEX_W  = $clog2(CFG_NUM_LINES);
  localparam int TAG_W    = CFG_ADDR_W - INDEX_W - OFFSET_W - 2;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_e;

  typedef struct packed {
    logic [TAG_W-1:0]    tag;
    logic [INDEX_W-1:0]  index;
    logic [OFFSET_W-1:0] offset;
  } addr_fields_t;

  // Byte address -> tag/index/word offset; the two byte-select bits are dropped
  function automatic addr_fields_t split_addr(input logic [CFG_ADDR_W-1:0] addr);
    addr_fields_t f;
    f.offset = addr[2 +: OFFSET_W];
    f.index  = addr[2 + OFFSET_W +: INDEX_W];
    f.tag    = addr[CFG_ADDR_W-1 -: TAG_W];
    return f;
  endfunction

endpackage

// File: rtl/l1_icache_array.sv
// rtl/l1_icache_array.sv - valid/tag/data storage with combinational read and single-word write
module icache_array
  import l1_icache_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 16
) (
  input  logic                clk,
  input  logic                clr_all,
  input  logic [INDEX_W-1:0]  rd_index,
  input  logic [OFFSET_W-1:0] rd_offset,
  output logic                rd_valid,
  output logic [TAG_W-1:0]    rd_tag,
  output logic [DATA_W-1:0]   rd_data,
  input  logic                wr_en,
  input  logic [INDEX_W-1:0]  wr_index,
  input  logic [OFFSET_W-1:0] wr_offset,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                wr_tag_en,
  input  logic [TAG_W-1:0]    wr_tag
);

  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]     tag_q [NUM_LINES];
  logic [TAG_W-1:0]     tag_d [NUM_LINES];
  logic [DATA_W-1:0]    data_mem [NUM_LINES*LINE_WORDS];

  // Next valid/tag: line completion sets valid, clear-all overrides it
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    if (wr_tag_en) begin
      valid_d[wr_index] = 1'b1;
      tag_d[wr_index]   = wr_tag;
    end
    if (clr_all) begin
      valid_d = '0;
    end
  end

  // Valid and tag registers
  always_ff @(posedge clk) begin
    valid_q <= valid_d;
    tag_q   <= tag_d;
  end

  // Data words are written one beat at a time and never reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_mem[{wr_index, wr_offset}] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_mem[{rd_index, rd_offset}];

endmodule

// File: rtl/l1_icache.sv
// rtl/l1_icache.sv - direct-mapped read-only L1 instruction cache with per-word refill
module l1_icache
  import l1_icache_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              flush,
  output logic [DATA_W-1:0] instr,
  output logic              stall,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
);

  localparam logic [OFFSET_W-1:0] LAST_BEAT = OFFSET_W'(LINE_WORDS - 1);

  state_e              state_q, state_d;
  logic [OFFSET_W-1:0] beat_q, beat_d;
  logic [TAG_W-1:0]    fill_tag_q, fill_tag_d;
  logic [INDEX_W-1:0]  fill_idx_q, fill_idx_d;
  logic                flush_pend_q, flush_pend_d;
  logic [31:0]         hit_cnt_q, hit_cnt_d;
  logic [31:0]         miss_cnt_q, miss_cnt_d;

  addr_fields_t        f;
  logic                rd_valid;
  logic [TAG_W-1:0]    rd_tag;
  logic [DATA_W-1:0]   rd_data;
  logic                hit;
  logic                wr_en, wr_tag_en, clr_all;

  assign f   = split_addr(cpu_addr);
  assign hit = (state_q == IDLE) && cpu_req && rd_valid && (rd_tag == f.tag);

  icache_array #(
    .DATA_W     (DATA_W),
    .LINE_WORDS (LINE_WORDS),
    .NUM_LINES  (NUM_LINES)
  ) u_array (
    .clk       (clk),
    .clr_all   (clr_all),
    .rd_index  (f.index),
    .rd_offset (f.offset),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_data   (rd_data),
    .wr_en     (wr_en),
    .wr_index  (fill_idx_q),
    .wr_offset (beat_q),
    .wr_data   (mem_rdata),
    .wr_tag_en (wr_tag_en),
    .wr_tag    (fill_tag_q)
  );

  // Lookup, miss capture, refill sequencing and counter updates
  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    fill_tag_d   = fill_tag_q;
    fill_idx_d   = fill_idx_q;
    flush_pend_d = flush_pend_q;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    stall        = 1'b0;
    mem_req      = 1'b0;
    mem_addr     = '0;
    wr_en        = 1'b0;
    wr_tag_en    = 1'b0;
    clr_all      = rst;
    unique case (state_q)
      IDLE: begin
        if (flush) clr_all = 1'b1;
        if (cpu_req) begin
          if (hit) begin
            hit_cnt_d = hit_cnt_q + 32'd1;
          end else begin
            stall        = 1'b1;
            miss_cnt_d   = miss_cnt_q + 32'd1;
            fill_tag_d   = f.tag;
            fill_idx_d   = f.index;
            beat_d       = '0;
            flush_pend_d = 1'b0;
            state_d      = FILL;
          end
        end
      end
      FILL: begin
        stall    = 1'b1;
        mem_req  = 1'b1;
        mem_addr = ADDR_W'({fill_tag_q, fill_idx_q, beat_q, 2'b00});
        if (flush) flush_pend_d = 1'b1;
        if (mem_ready) begin
          wr_en  = 1'b1;
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) begin
            wr_tag_en    = 1'b1;
            state_d      = IDLE;
            flush_pend_d = 1'b0;
            // A flush seen at any point of the fill drops the fresh line too
            if (flush_pend_q || flush) clr_all = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Controller state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      fill_tag_q   <= '0;
      fill_idx_q   <= '0;
      flush_pend_q <= 1'b0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      fill_tag_q   <= fill_tag_d;
      fill_idx_q   <= fill_idx_d;
      flush_pend_q <= flush_pend_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  assign instr    = hit ? rd_data : '0;
  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_l1_icache.sv
// tb/tb_l1_icache.sv - directed self-checking bench for l1_icache
module tb_l1_icache;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req;
  logic [31:0] cpu_addr;
  logic        flush;
  logic [31:0] instr;
  logic        stall;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
  logic [31:0] rdata_base;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  // Backing memory: word value = base + 0xA0 + beat number
  always_comb mem_rdata = rdata_base + 32'hA0 + 32'(mem_addr[3:2]);

  l1_icache dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_addr  (cpu_addr),
    .flush     (flush),
    .instr     (instr),
    .stall     (stall),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
  );

  task automatic do_reset;
    rst = 1'b1; cpu_req = 1'b0; cpu_addr = '0; flush = 1'b0;
    mem_ready = 1'b0; rdata_base = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    do_reset();
    checks++; if (stall !== 1'b0) $display("FAIL reset_stall got %0b want 0", stall); else passed++;
    checks++; if (mem_req !== 1'b0) $display("FAIL reset_mem_req got %0b want 0", mem_req); else passed++;
    checks++; if (mem_addr !== 32'h0) $display("FAIL reset_mem_addr got %h want 0", mem_addr); else passed++;
    checks++; if (instr !== 32'h0) $display("FAIL reset_instr got %h want 0", instr); else passed++;
    checks++; if (hit_cnt !== 32'h0 || miss_cnt !== 32'h0)
      $display("FAIL reset_counters got %0d/%0d want 0/0", hit_cnt, miss_cnt); else passed++;
  endtask

  task automatic test_miss_fill;
    @(negedge clk);
    cpu_req = 1'b1; cpu_addr = 32'h40; mem_ready = 1'b1;
    #1;
    checks++; if (stall !== 1'b1 || mem_req !== 1'b0)
      $display("FAIL miss_cycle0 got stall=%0b mem_req=%0b want 1/0", stall, mem_req); else passed++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h40 + 32'(4*i))
        $display("FAIL fill_beat%0d got mem_req=%0b addr=%h want 1/%h", i, mem_req, mem_addr, 32'h40 + 32'(4*i));
      else passed++;
    end
    @(negedge clk); #1;
    checks++; if (stall !== 1'b0 || instr !== 32'hA0)
      $display("FAIL fill_hit got stall=%0b instr=%h want 0/000000a0", stall, instr); else passed++;
    checks++; if (miss_cnt !== 32'd1) $display("FAIL miss_cnt1 got %0d want 1", miss_cnt); else passed++;
  endtask

  task automatic test_hit_conflict;
    @(negedge clk);
    cpu_addr = 32'h48;
    #1;
    checks++; if (instr !== 32'hA2 || stall !== 1'b0)
      $display("FAIL hit_0x48 got instr=%h stall=%0b want 000000a2/0", instr, stall); else passed++;
    checks++; if (hit_cnt !== 32'd1) $display("FAIL hit_cnt1 got %0d want 1", hit_cnt); else passed++;
    @(negedge clk);
    checks++; if (hit_cnt !== 32'd2) $display("FAIL hit_cnt2 got %0d want 2", hit_cnt); else passed++;
    cpu_addr = 32'h140; rdata_base = 32'h100;
    #1;
    checks++; if (stall !== 1'b1 || instr !== 32'h0)
      $display("FAIL conflict_miss got stall=%0b instr=%h want 1/0", stall, instr); else passed++;
    repeat (5) @(negedge clk);
    #1;
    checks++; if (stall !== 1'b0 || instr !== 32'h1A0)
      $display("FAIL conflict_hit got stall=%0b instr=%h want 0/000001a0", stall, instr); else passed++;
    checks++; if (miss_cnt !== 32'd2) $display("FAIL miss_cnt2 got %0d want 2", miss_cnt); else passed++;
    cpu_addr = 32'h40; rdata_base = 32'h0;
    #1;
    checks++; if (stall !== 1'b1) $display("FAIL evicted_miss got stall=%0b want 1", stall); else passed++;
    repeat (5) @(negedge clk);
    #1;
    checks++; if (stall !== 1'b0 || instr !== 32'hA0 || miss_cnt !== 32'd3)
      $display("FAIL refill_0x40 got stall=%0b instr=%h miss=%0d want 0/000000a0/3", stall, instr, miss_cnt);
    else passed++;
  endtask

  task automatic test_slow_ready;
    int stall_cycles;
    bit req_ok;
    bit addr_ok;
    do_reset();
    cpu_req = 1'b1; cpu_addr = 32'h40; mem_ready = 1'b0;
    #1;
    stall_cycles = stall ? 1 : 0;
    req_ok = 1'b1; addr_ok = 1'b1;
    for (int fc = 0; fc < 40; fc++) begin
      @(negedge clk);
      mem_ready = ((fc % 3) == 2);
      #1;
      if (!stall) break;
      stall_cycles++;
      if (mem_req !== 1'b1) req_ok = 1'b0;
      if (mem_addr !== 32'h40 + 32'(4*(fc/3))) addr_ok = 1'b0;
    end
    checks++; if (!req_ok) $display("FAIL slow_mem_req got dropped want held"); else passed++;
    checks++; if (!addr_ok) $display("FAIL slow_mem_addr got early advance want only on ready"); else passed++;
    checks++; if (stall_cycles != 13) $display("FAIL slow_stall_len got %0d want 13", stall_cycles); else passed++;
    checks++; if (instr !== 32'hA0) $display("FAIL slow_hit got %h want 000000a0", instr); else passed++;
  endtask

  task automatic test_flush;
    do_reset();
    cpu_req = 1'b1; cpu_addr = 32'h40; mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    flush = 1'b1;
    #1;
    checks++; if (mem_addr !== 32'h48) $display("FAIL flush_beat2 got %h want 00000048", mem_addr); else passed++;
    @(negedge clk);
    flush = 1'b0;
    @(negedge clk); #1;
    checks++; if (stall !== 1'b1 || instr !== 32'h0 || mem_req !== 1'b0)
      $display("FAIL flush_refetch got stall=%0b instr=%h mem_req=%0b want 1/0/0", stall, instr, mem_req);
    else passed++;
    @(negedge clk); #1;
    checks++; if (miss_cnt !== 32'd2 || mem_addr !== 32'h40 || mem_req !== 1'b1)
      $display("FAIL flush_miss_cnt got miss=%0d addr=%h want 2/00000040", miss_cnt, mem_addr); else passed++;
    repeat (4) @(negedge clk);
    flush = 1'b1;
    #1;
    checks++; if (stall !== 1'b0 || instr !== 32'hA0)
      $display("FAIL idle_flush_hit got stall=%0b instr=%h want 0/000000a0", stall, instr); else passed++;
    @(negedge clk);
    flush = 1'b0;
    #1;
    checks++; if (stall !== 1'b1 || hit_cnt !== 32'd1)
      $display("FAIL idle_flush_after got stall=%0b hit=%0d want 1/1", stall, hit_cnt); else passed++;
  endtask

  task automatic test_reset_mid_fill;
    do_reset();
    cpu_req = 1'b1; cpu_addr = 32'h40; mem_ready = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    checks++; if (mem_addr !== 32'h4C) $display("FAIL rst_beat3 got %h want 0000004c", mem_addr); else passed++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0 || stall !== 1'b1)
      $display("FAIL rst_mid_fill got mem_req=%0b stall=%0b want 0/1", mem_req, stall); else passed++;
    checks++; if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0)
      $display("FAIL rst_counters got %0d/%0d want 0/0", hit_cnt, miss_cnt); else passed++;
    @(negedge clk); #1;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h40)
      $display("FAIL rst_restart got mem_req=%0b addr=%h want 1/00000040", mem_req, mem_addr); else passed++;
  endtask

  task automatic test_idle_noreq;
    do_reset();
    cpu_req = 1'b1; cpu_addr = 32'h40; mem_ready = 1'b1;
    repeat (5) @(negedge clk);
    cpu_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cpu_addr = 32'h200 + 32'(i * 32'h104);
      #1;
      checks++; if (stall !== 1'b0 || mem_req !== 1'b0 || instr !== 32'h0)
        $display("FAIL noreq_%0d got stall=%0b mem_req=%0b instr=%h want 0/0/0", i, stall, mem_req, instr);
      else passed++;
      @(negedge clk);
    end
    #1;
    checks++; if (hit_cnt !== 32'd0 || miss_cnt !== 32'd1)
      $display("FAIL noreq_counters got %0d/%0d want 0/1", hit_cnt, miss_cnt); else passed++;
  endtask

  initial begin
    test_reset();
    test_miss_fill();
    test_hit_conflict();
    test_slow_ready();
    test_flush();
    test_reset_mid_fill();
    test_idle_noreq();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
